// File: rtl/vga_timing_gen.sv
// Free-running 1024x768@60 raster timing generator: counters, blank/sync, start-of-frame, char window.
// Optional VGA_FRAME_CNT_EN adds a 16-bit frame counter; otherwise frame_cnt is tied to 0.
module vga_timing_gen #(
  parameter int H_TOTAL  = 1344,
  parameter int V_TOTAL  = 806,
  parameter int H_ACTIVE = 1024,
  parameter int V_ACTIVE = 768,
  parameter int HS_START = 1048,
  parameter int HS_STOP  = 1184,
  parameter int VS_START = 771,
  parameter int VS_STOP  = 777,
  parameter int WIN_X    = 10,
  parameter int WIN_Y    = 40,
  parameter int WIN_W    = 128,
  parameter int WIN_H    = 256
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        en,
  output logic [10:0] hcount,
  output logic [10:0] vcount,
  output logic        hblnk,
  output logic        vblnk,
  output logic        hsync,
  output logic        vsync,
  output logic        sof,
  output logic        in_win,
  output logic [6:0]  win_x,
  output logic [7:0]  win_y,
  output logic [15:0] frame_cnt
);

  localparam logic [10:0] H_LAST  = 11'(H_TOTAL - 1);
  localparam logic [10:0] V_LAST  = 11'(V_TOTAL - 1);
  localparam logic [10:0] H_ACT   = 11'(H_ACTIVE);
  localparam logic [10:0] V_ACT   = 11'(V_ACTIVE);
  localparam logic [10:0] HS_ON   = 11'(HS_START);
  localparam logic [10:0] HS_OFF  = 11'(HS_STOP);
  localparam logic [10:0] VS_ON   = 11'(VS_START);
  localparam logic [10:0] VS_OFF  = 11'(VS_STOP);
  localparam logic [10:0] WX_LO   = 11'(WIN_X);
  localparam logic [10:0] WX_HI   = 11'(WIN_X + WIN_W);
  localparam logic [10:0] WY_LO   = 11'(WIN_Y);
  localparam logic [10:0] WY_HI   = 11'(WIN_Y + WIN_H);

  logic        h_wrap;
  logic        v_wrap;
  logic [10:0] h_nxt;
  logic [10:0] v_nxt;
  logic        sof_nxt;
  logic        win_nxt;
  logic [6:0]  wx_nxt;
  logic [7:0]  wy_nxt;

  // Flags are decoded from the next counter values so they register alongside the counters.
  always_comb begin
    h_wrap  = (hcount == H_LAST);
    v_wrap  = (vcount == V_LAST);
    h_nxt   = h_wrap ? 11'd0 : hcount + 11'd1;
    v_nxt   = vcount;
    if (h_wrap) begin
      v_nxt = v_wrap ? 11'd0 : vcount + 11'd1;
    end
    sof_nxt = h_wrap && v_wrap;
    win_nxt = (h_nxt >= WX_LO) && (h_nxt < WX_HI) &&
              (v_nxt >= WY_LO) && (v_nxt < WY_HI);
    wx_nxt  = win_nxt ? 7'(h_nxt - WX_LO) : 7'd0;
    wy_nxt  = win_nxt ? 8'(v_nxt - WY_LO) : 8'd0;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      hcount <= '0;
      vcount <= '0;
      hblnk  <= 1'b0;
      vblnk  <= 1'b0;
      hsync  <= 1'b0;
      vsync  <= 1'b0;
      sof    <= 1'b0;
      in_win <= 1'b0;
      win_x  <= '0;
      win_y  <= '0;
    end else if (en) begin
      hcount <= h_nxt;
      vcount <= v_nxt;
      hblnk  <= (h_nxt >= H_ACT);
      vblnk  <= (v_nxt >= V_ACT);
      hsync  <= (h_nxt >= HS_ON) && (h_nxt < HS_OFF);
      vsync  <= (v_nxt >= VS_ON) && (v_nxt < VS_OFF);
      sof    <= sof_nxt;
      in_win <= win_nxt;
      win_x  <= wx_nxt;
      win_y  <= wy_nxt;
    end
  end

`ifdef VGA_FRAME_CNT_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      frame_cnt <= '0;
    end else if (en && sof_nxt) begin
      frame_cnt <= frame_cnt + 16'd1;
    end
  end
`else
  assign frame_cnt = 16'd0;
`endif

endmodule

// File: tb/tb_vga_timing_gen.sv
// Bench for vga_timing_gen: full-size instance for line/window timing, shrunk-raster instance for whole frames.
// Both are checked every cycle against an arithmetic raster model driven by the count of enabled edges.
module tb_vga_timing_gen;

  typedef struct packed {
    int ht; int vt; int ha; int va; int hs0; int hs1; int vs0; int vs1;
    int wx; int wy; int ww; int wh;
  } tp_t;

  localparam tp_t PD = '{ht: 1344, vt: 806, ha: 1024, va: 768, hs0: 1048, hs1: 1184,
                          vs0: 771, vs1: 777, wx: 10, wy: 40, ww: 128, wh: 256};
  localparam tp_t PS = '{ht: 64, vt: 40, ha: 40, va: 30, hs0: 44, hs1: 52,
                          vs0: 32, vs1: 35, wx: 5, wy: 4, ww: 16, wh: 8};
  localparam longint SF = 64 * 40;

  logic clk = 1'b0;
  logic rst_n;
  logic en;

  logic [10:0] d_h, d_v, s_h, s_v;
  logic        d_hb, d_vb, d_hs, d_vs, d_sof, d_in;
  logic        s_hb, s_vb, s_hs, s_vs, s_sof, s_in;
  logic [6:0]  d_wx, s_wx;
  logic [7:0]  d_wy, s_wy;
  logic [15:0] d_fc, s_fc;

  int     checks = 0;
  int     errors = 0;
  longint t = 0;
  int     cyc;

  always #5 clk = ~clk;

  vga_timing_gen dut_d (
    .clk(clk), .rst_n(rst_n), .en(en), .hcount(d_h), .vcount(d_v), .hblnk(d_hb), .vblnk(d_vb),
    .hsync(d_hs), .vsync(d_vs), .sof(d_sof), .in_win(d_in), .win_x(d_wx), .win_y(d_wy),
    .frame_cnt(d_fc)
  );

  vga_timing_gen #(
    .H_TOTAL(PS.ht), .V_TOTAL(PS.vt), .H_ACTIVE(PS.ha), .V_ACTIVE(PS.va),
    .HS_START(PS.hs0), .HS_STOP(PS.hs1), .VS_START(PS.vs0), .VS_STOP(PS.vs1),
    .WIN_X(PS.wx), .WIN_Y(PS.wy), .WIN_W(PS.ww), .WIN_H(PS.wh)
  ) dut_s (
    .clk(clk), .rst_n(rst_n), .en(en), .hcount(s_h), .vcount(s_v), .hblnk(s_hb), .vblnk(s_vb),
    .hsync(s_hs), .vsync(s_vs), .sof(s_sof), .in_win(s_in), .win_x(s_wx), .win_y(s_wy),
    .frame_cnt(s_fc)
  );

  wire [58:0] d_pack = {d_h, d_v, d_hb, d_vb, d_hs, d_vs, d_sof, d_in, d_wx, d_wy, d_fc};
  wire [58:0] s_pack = {s_h, s_v, s_hb, s_vb, s_hs, s_vs, s_sof, s_in, s_wx, s_wy, s_fc};

  // Outputs as a pure function of how many enabled edges have elapsed since reset.
  function automatic logic [58:0] model(longint tt, tp_t p);
    longint h, v, fr;
    logic in_w;
    logic [6:0] wx;
    logic [7:0] wy;
    logic [15:0] fc;
    h    = tt % p.ht;
    v    = (tt / p.ht) % p.vt;
    fr   = tt / (p.ht * p.vt);
    in_w = (h >= p.wx) && (h < p.wx + p.ww) && (v >= p.wy) && (v < p.wy + p.wh);
    wx   = in_w ? 7'(h - p.wx) : 7'd0;
    wy   = in_w ? 8'(v - p.wy) : 8'd0;
    fc   = 16'(fr);
`ifndef VGA_FRAME_CNT_EN
    fc   = 16'd0;
`endif
    return {11'(h), 11'(v), h >= p.ha, v >= p.va, (h >= p.hs0) && (h < p.hs1),
            (v >= p.vs0) && (v < p.vs1), (tt > 0) && ((tt % (p.ht * p.vt)) == 0),
            in_w, wx, wy, fc};
  endfunction

  task automatic lit(input string nm, input longint act, input longint exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s t=%0d got %0d expected %0d", nm, t, act, exp);
    end
  endtask

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) t <= 0;
    else if (en) t <= t + 1;
  end

  always @(negedge clk) begin
    logic [58:0] ed, es;
    ed = model(t, PD);
    es = model(t, PS);
    checks += 2;
    if (d_pack !== ed) begin
      errors++;
      $display("FAIL cmp_full t=%0d got %h expected %h", t, d_pack, ed);
    end
    if (s_pack !== es) begin
      errors++;
      $display("FAIL cmp_small t=%0d got %h expected %h", t, s_pack, es);
    end
    case (t)
      1023:  begin lit("h1023", d_h, 1023); lit("hblnk_off", d_hb, 0); end
      1024:  begin lit("h1024", d_h, 1024); lit("hblnk_on", d_hb, 1); end
      1047:  lit("hsync_pre", d_hs, 0);
      1048:  lit("hsync_on", d_hs, 1);
      1183:  lit("hsync_last", d_hs, 1);
      1184:  lit("hsync_off", d_hs, 0);
      1344:  begin lit("line1_h", d_h, 0); lit("line1_v", d_v, 1); lit("line1_hb", d_hb, 0); lit("line1_sof", d_sof, 0); end
      53769: lit("win_l_out", d_in, 0);
      53770: begin lit("win_l_in", d_in, 1); lit("win_x0", d_wx, 0); lit("win_y0", d_wy, 0); end
      53897: lit("win_x127", d_wx, 127);
      53898: begin lit("win_r_out", d_in, 0); lit("win_r_x", d_wx, 0); end
      default: ;
    endcase
    if (t == SF) begin
      lit("s_sof", s_sof, 1); lit("s_h0", s_h, 0); lit("s_v0", s_v, 0); lit("s_vb", s_vb, 0);
`ifdef VGA_FRAME_CNT_EN
      lit("s_fc1", s_fc, 1);
`else
      lit("s_fc0", s_fc, 0);
`endif
    end
    if (t == SF + 1) lit("s_sof_clr", s_sof, 0);
    if (t == 11 * 64 + 5) begin lit("s_wy7", s_wy, 7); lit("s_in_bot", s_in, 1); end
    if (t == 12 * 64 + 5) lit("s_out_bot", s_in, 0);
    if (t == 32 * 64) lit("s_vsync_on", s_vs, 1);
    if (t == 35 * 64) lit("s_vsync_off", s_vs, 0);
  end

  initial begin
    rst_n = 1'b0;
    en    = 1'b0;
    repeat (3) @(negedge clk);
    lit("rst_full", d_pack, 0);
    lit("rst_small", s_pack, 0);
    rst_n = 1'b1;
    cyc = 0;
    while (t < 53950 && cyc < 80000) begin
      @(negedge clk);
      en = ($urandom_range(0, 9) != 0);
      cyc++;
    end
    if (t < 53950) begin
      errors++;
      $display("FAIL budget t=%0d got %0d cycles expected fewer than 80000", t, cyc);
    end
    @(negedge clk);
    #3 rst_n = 1'b0;
    #1;
    lit("async_full", d_pack, 0);
    lit("async_small", s_pack, 0);
    @(negedge clk);
    rst_n = 1'b1;
    en    = 1'b1;
    @(posedge clk);
    #1 lit("restart_h1", d_h, 1);
    repeat (3000) begin
      @(negedge clk);
      en = ($urandom_range(0, 3) != 0);
    end
    @(negedge clk);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
